ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (ex_aluop, ex_r1_data, ex_r2_data).
- Raises a stall request while computing, so ID/EX and earlier stages hold the instruction stable.
- Releases the stall and presents a 32-bit result for the EX result mux.
- Handles all eight M-extension ops, including the RISC-V divide-by-zero and overflow rules.

---
 rtl/ex_muldiv_if.sv | 25 ++
 rtl/ex_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Bundle between the ID/EX register, the stall controller and the EX-stage
// iterative multiply/divide unit.
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic [7:0]        ex_aluop;
    logic [DATA_W-1:0] ex_r1_data;
    logic [DATA_W-1:0] ex_r2_data;
    logic              hold;
    logic              flush;
    logic              md_stall_req;
    logic [DATA_W-1:0] md_result;
    logic              md_valid;
    logic              md_busy;

    modport master (
        output ex_aluop, ex_r1_data, ex_r2_data, hold, flush,
        input  md_stall_req, md_result, md_valid, md_busy
    );

    modport slave (
        input  ex_aluop, ex_r1_data, ex_r2_data, hold, flush,
        output md_stall_req, md_result, md_valid, md_busy
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the front end while busy.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle with a combinational multiplier.
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam logic [7:0] EX_MUL_OP    = 8'h40;
    localparam logic [7:0] EX_MULH_OP   = 8'h41;
    localparam logic [7:0] EX_MULHSU_OP = 8'h42;
    localparam logic [7:0] EX_MULHU_OP  = 8'h43;
    localparam logic [7:0] EX_DIV_OP    = 8'h44;
    localparam logic [7:0] EX_DIVU_OP   = 8'h45;
    localparam logic [7:0] EX_REM_OP    = 8'h46;
    localparam logic [7:0] EX_REMU_OP   = 8'h47;

    localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] { IDLE, BUSY, DONE } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opd_q, opd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                div_q, div_d;
    logic                hi_q, hi_d;
    logic                neg_q, neg_d;
    logic                nrem_q, nrem_d;
    logic                stall;

    logic is_mul, is_div, hi_sel, s1_signed, s2_signed;

    // hi_sel picks the high product word for multiplies, the remainder for divides.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        is_mul    = 1'b0;
        is_div    = 1'b0;
        hi_sel    = 1'b0;
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        case (bus.ex_aluop)
            EX_MUL_OP:    begin is_mul = 1'b1; s1_signed = 1'b1; s2_signed = 1'b1; end
            EX_MULH_OP:   begin is_mul = 1'b1; hi_sel = 1'b1; s1_signed = 1'b1; s2_signed = 1'b1; end
            EX_MULHSU_OP: begin is_mul = 1'b1; hi_sel = 1'b1; s1_signed = 1'b1; end
            EX_MULHU_OP:  begin is_mul = 1'b1; hi_sel = 1'b1; end
            EX_DIV_OP:    begin is_div = 1'b1; s1_signed = 1'b1; s2_signed = 1'b1; end
            EX_DIVU_OP:   begin is_div = 1'b1; end
            EX_REM_OP:    begin is_div = 1'b1; hi_sel = 1'b1; s1_signed = 1'b1; s2_signed = 1'b1; end
            EX_REMU_OP:   begin is_div = 1'b1; hi_sel = 1'b1; end
            default:      ;
        endcase
    end

    logic              s1, s2;
    logic [DATA_W-1:0] mag1, mag2;
    logic              div_zero, div_ovf;

    assign s1       = s1_signed & bus.ex_r1_data[DATA_W-1];
    assign s2       = s2_signed & bus.ex_r2_data[DATA_W-1];
    assign mag1     = s1 ? -bus.ex_r1_data : bus.ex_r1_data;
    assign mag2     = s2 ? -bus.ex_r2_data : bus.ex_r2_data;
    assign div_zero = is_div & (bus.ex_r2_data == '0);
    assign div_ovf  = is_div & s1_signed & (bus.ex_r1_data == INT_MIN) & (bus.ex_r2_data == '1);

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic [DATA_W-1:0]   div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] step_nxt, prod_s;
    logic [DATA_W-1:0]   quo, rem, fix_res;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign div_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_ge   = div_sh >= {1'b0, opd_q};
    assign div_diff = div_sh[DATA_W-1:0] - opd_q;
    assign step_nxt = div_q ? (div_ge ? {div_diff, acc_q[DATA_W-2:0], 1'b1}
                                      : {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0})
                            : {mul_sum, acc_q[DATA_W-1:1]};

    assign prod_s  = neg_q ? -step_nxt : step_nxt;
    assign quo     = step_nxt[DATA_W-1:0];
    assign rem     = step_nxt[2*DATA_W-1:DATA_W];
    assign fix_res = div_q ? (hi_q ? (nrem_q ? -rem : rem) : (neg_q ? -quo : quo))
                           : (hi_q ? prod_s[2*DATA_W-1:DATA_W] : prod_s[DATA_W-1:0]);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod, fast_s;
    assign fast_prod = {{DATA_W{1'b0}}, mag1} * {{DATA_W{1'b0}}, mag2};
    assign fast_s    = (s1 ^ s2) ? -fast_prod : fast_prod;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        result_d = result_q;
        div_d    = div_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        nrem_d   = nrem_q;
        stall    = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mul | is_div) begin
                        stall  = 1'b1;
                        div_d  = is_div;
                        hi_d   = hi_sel;
                        neg_d  = s1 ^ s2;
                        nrem_d = s1;
                        cnt_d  = '0;
                        if (div_zero) begin
                            result_d = hi_sel ? bus.ex_r1_data : '1;
                            state_d  = DONE;
                        end else if (div_ovf) begin
                            result_d = hi_sel ? '0 : INT_MIN;
                            state_d  = DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (is_mul) begin
                            result_d = hi_sel ? fast_s[2*DATA_W-1:DATA_W] : fast_s[DATA_W-1:0];
                            state_d  = DONE;
`endif
                        end else begin
                            opd_d   = is_div ? mag2 : mag1;
                            acc_d   = {{DATA_W{1'b0}}, is_div ? mag1 : mag2};
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    acc_d = step_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = fix_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    // Leaving DONE consumes the instruction; the same aluop is not restarted.
                    if (!bus.hold) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            result_q <= '0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            nrem_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            result_q <= result_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            neg_q    <= neg_d;
            nrem_q   <= nrem_d;
        end
    end

    // Gated with rst so the stall request drops with the rest of the outputs during reset.
    assign bus.md_stall_req = stall & rst;
    assign bus.md_result    = result_q;
    assign bus.md_valid     = (state_q == DONE);
    assign bus.md_busy      = (state_q == BUSY);

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M cases, flush/hold/reset scenarios and random ops.
module tb_ex_muldiv;

  localparam int DATA_W = 32;

  localparam logic [7:0] NOP_OP       = 8'h00;
  localparam logic [7:0] EX_MUL_OP    = 8'h40;
  localparam logic [7:0] EX_MULH_OP   = 8'h41;
  localparam logic [7:0] EX_MULHSU_OP = 8'h42;
  localparam logic [7:0] EX_MULHU_OP  = 8'h43;
  localparam logic [7:0] EX_DIV_OP    = 8'h44;
  localparam logic [7:0] EX_DIVU_OP   = 8'h45;
  localparam logic [7:0] EX_REM_OP    = 8'h46;
  localparam logic [7:0] EX_REMU_OP   = 8'h47;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_muldiv_if #(.DATA_W(DATA_W)) bus ();

  ex_muldiv #(.DATA_W(DATA_W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      EX_MUL_OP:    begin p = sa * sb; return p[31:0];  end
      EX_MULH_OP:   begin p = sa * sb; return p[63:32]; end
      EX_MULHSU_OP: begin p = sa * ub; return p[63:32]; end
      EX_MULHU_OP:  begin p = ua * ub; return p[63:32]; end
      EX_DIV_OP: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      EX_DIVU_OP: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      EX_REM_OP: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      EX_REMU_OP: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    is_div = (op == EX_DIV_OP) || (op == EX_DIVU_OP) || (op == EX_REM_OP) || (op == EX_REMU_OP);
    if (is_div) begin
      if (b == 0) return 1;
      if ((op == EX_DIV_OP || op == EX_REM_OP) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return 1;
      return DATA_W + 1;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return DATA_W + 1;
`endif
  endfunction

  // Monitor: one scoreboard pop per valid result presented.
  always @(negedge clk) begin
    if (bus.md_valid && !seen) begin
      seen <= 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with no expected entry at %0t", bus.md_result, $time);
      end else begin
        check("result", bus.md_result, exp_q.pop_front());
      end
    end else if (!bus.md_valid) begin
      seen <= 1'b0;
    end
  end

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int hold_cyc);
    int lat;
    bit stall_ok;
    @(posedge clk); #1;
    bus.ex_aluop   = op;
    bus.ex_r1_data = a;
    bus.ex_r2_data = b;
    bus.hold       = 1'b0;
    bus.flush      = 1'b0;
    exp_q.push_back(exp_res);
    lat      = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    while (!bus.md_valid && lat < 100) begin
      if (!bus.md_stall_req) stall_ok = 1'b0;
      lat++;
      @(negedge clk);
    end
    check("latency", lat, exp_lat(op, a, b));
    check("stall_until_done", {31'b0, stall_ok}, 32'd1);
    check("stall_in_done", {31'b0, bus.md_stall_req}, 32'd0);
    if (hold_cyc > 0) begin
      bus.hold = 1'b1;
      for (int i = 0; i < hold_cyc; i++) begin
        @(negedge clk);
        check("hold_valid", {31'b0, bus.md_valid}, 32'd1);
        check("hold_result", bus.md_result, exp_res);
      end
      bus.hold = 1'b0;
    end
    @(posedge clk); #1;
    bus.ex_aluop = NOP_OP;
    @(negedge clk);
    check("idle_valid", {31'b0, bus.md_valid}, 32'd0);
    check("idle_busy", {31'b0, bus.md_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a, b;
    bit          valid_seen;

    rst            = 1'b0;
    bus.ex_aluop   = NOP_OP;
    bus.ex_r1_data = '0;
    bus.ex_r2_data = '0;
    bus.hold       = 1'b0;
    bus.flush      = 1'b0;
    #3;
    check("rst_stall", {31'b0, bus.md_stall_req}, 32'd0);
    check("rst_valid", {31'b0, bus.md_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.md_busy}, 32'd0);
    check("rst_result", bus.md_result, 32'd0);
    #20 rst = 1'b1;

    // Directed vectors; first one also exercises three cycles of hold in DONE.
    run_op(EX_MUL_OP,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
    run_op(EX_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(EX_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(EX_MULHSU_OP, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
    run_op(EX_DIV_OP,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_op(EX_REM_OP,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_op(EX_DIVU_OP,   32'd100,       32'd7,         32'd14,        0);
    run_op(EX_REMU_OP,   32'd100,       32'd7,         32'd2,         0);
    run_op(EX_DIV_OP,    32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op(EX_REM_OP,    32'd5,         32'd0,         32'd5,         0);
    run_op(EX_DIVU_OP,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op(EX_REMU_OP,   32'd5,         32'd0,         32'd5,         0);
    run_op(EX_DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(EX_REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2);

    // Flush a DIVU during its tenth cycle.
    @(posedge clk); #1;
    bus.ex_aluop   = EX_DIVU_OP;
    bus.ex_r1_data = 32'd1000;
    bus.ex_r2_data = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_flush", {31'b0, bus.md_busy}, 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, bus.md_stall_req}, 32'd0);
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.ex_aluop = NOP_OP;
    @(negedge clk);
    check("flush_idle_busy", {31'b0, bus.md_busy}, 32'd0);
    valid_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.md_valid) valid_seen = 1'b1;
    end
    check("flush_no_valid", {31'b0, valid_seen}, 32'd0);
    run_op(EX_DIVU_OP, 32'd9, 32'd3, 32'd3, 0);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    bus.ex_aluop   = EX_DIV_OP;
    bus.ex_r1_data = 32'd1000;
    bus.ex_r2_data = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_rst", {31'b0, bus.md_busy}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_stall", {31'b0, bus.md_stall_req}, 32'd0);
    check("midrst_valid", {31'b0, bus.md_valid}, 32'd0);
    check("midrst_busy", {31'b0, bus.md_busy}, 32'd0);
    check("midrst_result", bus.md_result, 32'd0);
    bus.ex_aluop = NOP_OP;
    #3 rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'b0, bus.md_busy}, 32'd0);

    // Random ops with corner-biased operands.
    for (int n = 0; n < 40; n++) begin
      op = 8'h40 + 8'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_op(op, a, b, ref_model(op, a, b), int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
